// File: rtl/regs_pkg.sv
// Shared constants and FSM state type for the register-file access controller.
package regs_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic [2:0] {
    IDLE,
    WB_SETUP,
    WB_STROBE,
    RD_SETUP,
    RD_STROBE,
    RSP
  } regs_ctrl_state_t;

endpackage

// File: rtl/regs_access_ctrl_if.sv
// Core-side request/response handshakes and register-file strobe pins of regs_access_ctrl.
interface regs_access_ctrl_if #(
  parameter int XLEN = regs_pkg::XLEN,
  parameter int AW   = regs_pkg::AW
);

  // A transfer happens on the rising clk edge where valid and ready are both 1;
  // the initiator holds valid and its payload stable until that edge.
  logic            rd_req_valid;
  logic            rd_req_ready;
  logic [AW-1:0]   rs1_idx;
  logic [AW-1:0]   rs2_idx;
  logic            rd_rsp_valid;
  logic            rd_rsp_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_idx;
  logic [XLEN-1:0] wb_data;

  logic            rf_req_r;
  logic            rf_req_w;
  logic            rf_rs_read_n;
  logic [AW-1:0]   rf_rs1;
  logic [AW-1:0]   rf_rs2;
  logic [AW-1:0]   rf_rd;
  logic            rf_rd_write_n;
  logic [XLEN-1:0] rf_rd_value;
  logic [XLEN-1:0] rf_rs1_value;
  logic [XLEN-1:0] rf_rs2_value;

  modport slave (
    input  rd_req_valid, rs1_idx, rs2_idx, rd_rsp_ready,
    input  wb_valid, wb_idx, wb_data,
    input  rf_rs1_value, rf_rs2_value,
    output rd_req_ready, rd_rsp_valid, rs1_data, rs2_data, wb_ready,
    output rf_req_r, rf_req_w, rf_rs_read_n, rf_rs1, rf_rs2,
    output rf_rd, rf_rd_write_n, rf_rd_value
  );

  modport master (
    output rd_req_valid, rs1_idx, rs2_idx, rd_rsp_ready,
    output wb_valid, wb_idx, wb_data,
    output rf_rs1_value, rf_rs2_value,
    input  rd_req_ready, rd_rsp_valid, rs1_data, rs2_data, wb_ready,
    input  rf_req_r, rf_req_w, rf_rs_read_n, rf_rs1, rf_rs2,
    input  rf_rd, rf_rd_write_n, rf_rd_value
  );

endinterface

// File: rtl/regs_bypass_shadow.sv
// One-entry copy of the most recent non-zero write; lets reads of x0 or that
// register skip the file strobe. Used only when REGS_BYPASS_EN is defined.
module regs_bypass_shadow #(
  parameter int XLEN = regs_pkg::XLEN,
  parameter int AW   = regs_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd_en,
  input  logic [AW-1:0]   upd_idx,
  input  logic [XLEN-1:0] upd_data,
  input  logic [AW-1:0]   rs1_idx,
  input  logic [AW-1:0]   rs2_idx,
  output logic            rs1_hit,
  output logic            rs2_hit,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic            valid_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else if (upd_en) begin
      valid_q <= 1'b1;
      idx_q   <= upd_idx;
      data_q  <= upd_data;
    end
  end

  // x0 always hits and reads as zero.
  assign rs1_hit  = (rs1_idx == '0) || (valid_q && (rs1_idx == idx_q));
  assign rs2_hit  = (rs2_idx == '0) || (valid_q && (rs2_idx == idx_q));
  assign rs1_data = (rs1_idx == '0) ? '0 : data_q;
  assign rs2_data = (rs2_idx == '0) ? '0 : data_q;

endmodule

// File: rtl/regs_access_ctrl.sv
// Sole initiator of the strobe-driven register file: turns read/writeback
// handshakes into setup+strobe sequences. Optional shadow bypass: REGS_BYPASS_EN.
module regs_access_ctrl #(
  parameter int XLEN = regs_pkg::XLEN,
  parameter int AW   = regs_pkg::AW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  regs_access_ctrl_if.slave           bus,
  output regs_pkg::regs_ctrl_state_t  dbg_state
);
  import regs_pkg::*;

  regs_ctrl_state_t state_q, state_d;
  logic             ready_en_q;
  logic [AW-1:0]    wb_idx_q, rs1_idx_q, rs2_idx_q;
  logic [XLEN-1:0]  wb_data_q, rs1_data_q, rs2_data_q;
  logic             idle, wb_acc, rd_acc, bypass_hit;
  logic [XLEN-1:0]  byp_rs1_data, byp_rs2_data;
  logic             req_w, req_r, write_n, read_n, rsp_valid;

  // ready_en_q holds off acceptance until the first clock edge after reset.
  assign idle             = (state_q == IDLE) && ready_en_q;
  assign bus.wb_ready     = idle;
  assign bus.rd_req_ready = idle && !bus.wb_valid;
  assign wb_acc           = bus.wb_valid && idle;
  assign rd_acc           = bus.rd_req_valid && bus.rd_req_ready;

`ifdef REGS_BYPASS_EN
  logic rs1_hit, rs2_hit;

  regs_bypass_shadow #(.XLEN(XLEN), .AW(AW)) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .upd_en   (wb_acc && (bus.wb_idx != '0)),
    .upd_idx  (bus.wb_idx),
    .upd_data (bus.wb_data),
    .rs1_idx  (bus.rs1_idx),
    .rs2_idx  (bus.rs2_idx),
    .rs1_hit  (rs1_hit),
    .rs2_hit  (rs2_hit),
    .rs1_data (byp_rs1_data),
    .rs2_data (byp_rs2_data)
  );

  assign bypass_hit = rs1_hit && rs2_hit;
`else
  assign bypass_hit   = 1'b0;
  assign byp_rs1_data = '0;
  assign byp_rs2_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    req_w     = 1'b0;
    req_r     = 1'b0;
    write_n   = 1'b1;
    read_n    = 1'b1;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // Writeback has priority so a same-cycle read observes the new value.
        if (wb_acc) begin
          if (bus.wb_idx != '0) state_d = WB_SETUP;
        end else if (rd_acc) begin
          state_d = bypass_hit ? RSP : RD_SETUP;
        end
      end
      WB_SETUP: begin
        write_n = 1'b0;
        state_d = WB_STROBE;
      end
      WB_STROBE: begin
        write_n = 1'b0;
        req_w   = 1'b1;
        state_d = IDLE;
      end
      RD_SETUP: begin
        read_n  = 1'b0;
        state_d = RD_STROBE;
      end
      RD_STROBE: begin
        read_n  = 1'b0;
        req_r   = 1'b1;
        state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (bus.rd_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      rs1_idx_q  <= '0;
      rs2_idx_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (wb_acc && (bus.wb_idx != '0)) begin
        wb_idx_q  <= bus.wb_idx;
        wb_data_q <= bus.wb_data;
      end
      if (rd_acc) begin
        rs1_idx_q <= bus.rs1_idx;
        rs2_idx_q <= bus.rs2_idx;
      end
      // File data is valid while the read strobe is high; take it on the way out.
      if (rd_acc && bypass_hit) begin
        rs1_data_q <= byp_rs1_data;
        rs2_data_q <= byp_rs2_data;
      end else if (state_q == RD_STROBE) begin
        rs1_data_q <= bus.rf_rs1_value;
        rs2_data_q <= bus.rf_rs2_value;
      end
    end
  end

  assign bus.rf_req_w      = req_w;
  assign bus.rf_req_r      = req_r;
  assign bus.rf_rd_write_n = write_n;
  assign bus.rf_rs_read_n  = read_n;
  assign bus.rf_rd         = wb_idx_q;
  assign bus.rf_rd_value   = wb_data_q;
  assign bus.rf_rs1        = rs1_idx_q;
  assign bus.rf_rs2        = rs2_idx_q;
  assign bus.rd_rsp_valid  = rsp_valid;
  assign bus.rs1_data      = rs1_data_q;
  assign bus.rs2_data      = rs2_data_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_regs_access_ctrl.sv
// Bench for regs_access_ctrl: register-file model on the strobe pins, a
// cycle-timeline reference model checked every cycle, and directed scenarios.
module tb_regs_access_ctrl;
  import regs_pkg::*;

  localparam int K_WR = 1;
  localparam int K_RD = 2;
`ifdef REGS_BYPASS_EN
  localparam int SHORT_LAT = 1;
`else
  localparam int SHORT_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  regs_ctrl_state_t dbg_state;

  regs_access_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regs_access_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- counters and compare helper ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- register file model on the strobe pins ----------------
  logic [XLEN-1:0] file_mem [32] = '{default: '0};
  int wstrobe_cnt = 0;
  int wn_low_cnt  = 0;

  always @(posedge bus.rf_req_w) begin
    wstrobe_cnt++;
    if (!bus.rf_rd_write_n) file_mem[bus.rf_rd] = bus.rf_rd_value;
  end

  always @(negedge clk) if (rst_n && !bus.rf_rd_write_n) wn_low_cnt++;

  assign bus.rf_rs1_value = bus.rf_rs_read_n ? '0 : file_mem[bus.rf_rs1];
  assign bus.rf_rs2_value = bus.rf_rs_read_n ? '0 : file_mem[bus.rf_rs2];

  // ---------------- reference model ----------------
  logic [XLEN-1:0]   ref_rf [32] = '{default: '0};
  logic [2*XLEN-1:0] exp_q[$];
  bit                busy = 1'b0;
  int                kind = 0;
  int                acc = 0;
  int                rsp_start = 0;
  int                cyc = 0;
  logic [AW-1:0]     m_widx, m_rs1, m_rs2;
  logic [XLEN-1:0]   m_wdata;
  bit                sh_valid = 1'b0;
  logic [AW-1:0]     sh_idx;
  logic [XLEN-1:0]   sh_data;
  bit                armed = 1'b0;

  // Requests may be taken from the first cycle after a clock edge seen out of reset.
  always @(posedge clk or negedge rst_n) armed = rst_n;

  always @(negedge clk) begin
    bit free, wn, rw, rn, rr, rv, hit;
    cyc++;
    if (!rst_n) begin
      busy     = 1'b0;
      sh_valid = 1'b0;
      exp_q.delete();
      chk("rst_req_w",    bus.rf_req_w, 0);
      chk("rst_req_r",    bus.rf_req_r, 0);
      chk("rst_read_n",   bus.rf_rs_read_n, 1);
      chk("rst_write_n",  bus.rf_rd_write_n, 1);
      chk("rst_rsp_v",    bus.rd_rsp_valid, 0);
      chk("rst_wb_rdy",   bus.wb_ready, 0);
      chk("rst_rd_rdy",   bus.rd_req_ready, 0);
      chk("rst_idx",      {bus.rf_rs1, bus.rf_rs2, bus.rf_rd}, 0);
      chk("rst_wval",     bus.rf_rd_value, 0);
      chk("rst_rsp_data", {bus.rs1_data, bus.rs2_data}, 0);
    end else begin
      if (busy && kind == K_WR && cyc >= acc + 3) busy = 1'b0;
      free = armed && !busy;
      wn = busy && kind == K_WR && (cyc == acc + 1 || cyc == acc + 2);
      rw = busy && kind == K_WR && cyc == acc + 2;
      rn = busy && kind == K_RD && rsp_start == acc + 3 && (cyc == acc + 1 || cyc == acc + 2);
      rr = rn && cyc == acc + 2;
      rv = busy && kind == K_RD && cyc >= rsp_start;
      chk("wb_ready",      bus.wb_ready, free);
      chk("rd_req_ready",  bus.rd_req_ready, free && !bus.wb_valid);
      chk("rf_req_w",      bus.rf_req_w, rw);
      chk("rf_rd_write_n", bus.rf_rd_write_n, !wn);
      chk("rf_req_r",      bus.rf_req_r, rr);
      chk("rf_rs_read_n",  bus.rf_rs_read_n, !rn);
      chk("rd_rsp_valid",  bus.rd_rsp_valid, rv);
      if (wn) begin
        chk("rf_rd",       bus.rf_rd, m_widx);
        chk("rf_rd_value", bus.rf_rd_value, m_wdata);
      end
      if (rn) chk("rf_rs_idx", {bus.rf_rs1, bus.rf_rs2}, {m_rs1, m_rs2});
      if (rv) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("rsp_data", {bus.rs1_data, bus.rs2_data}, exp_q[0]);
        if (bus.rd_rsp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          busy = 1'b0;
        end
      end
      if (free && bus.wb_valid) begin
        if (bus.wb_idx != '0) begin
          busy    = 1'b1;
          kind    = K_WR;
          acc     = cyc;
          m_widx  = bus.wb_idx;
          m_wdata = bus.wb_data;
          ref_rf[bus.wb_idx] = bus.wb_data;
          sh_valid = 1'b1;
          sh_idx   = bus.wb_idx;
          sh_data  = bus.wb_data;
        end
      end else if (free && bus.rd_req_valid) begin
`ifdef REGS_BYPASS_EN
        hit = (bus.rs1_idx == '0 || (sh_valid && bus.rs1_idx == sh_idx)) &&
              (bus.rs2_idx == '0 || (sh_valid && bus.rs2_idx == sh_idx));
`else
        hit = 1'b0;
`endif
        busy      = 1'b1;
        kind      = K_RD;
        acc       = cyc;
        rsp_start = hit ? cyc + 1 : cyc + 3;
        m_rs1     = bus.rs1_idx;
        m_rs2     = bus.rs2_idx;
        exp_q.push_back({ref_rf[bus.rs1_idx], ref_rf[bus.rs2_idx]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a writeback and/or read at once; rsp_cyc counts cycles from presentation.
  task automatic run_txn(input bit wv, input logic [AW-1:0] widx, input logic [XLEN-1:0] wdata,
                         input bit rv, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         output int rsp_cyc, output logic [XLEN-1:0] d1, output logic [XLEN-1:0] d2);
    bit wdone, racc, got, fin;
    wdone = !wv; racc = !rv; got = 1'b0; fin = 1'b0;
    rsp_cyc = -1; d1 = '0; d2 = '0;
    bus.wb_valid = wv; bus.wb_idx = widx; bus.wb_data = wdata;
    bus.rd_req_valid = rv; bus.rs1_idx = r1; bus.rs2_idx = r2;
    for (int n = 0; n < 60 && !fin; n++) begin
      @(negedge clk);
      if (bus.wb_valid && bus.wb_ready) wdone = 1'b1;
      if (bus.rd_req_valid && bus.rd_req_ready) racc = 1'b1;
      if (bus.rd_rsp_valid && !got) begin
        got = 1'b1; rsp_cyc = n; d1 = bus.rs1_data; d2 = bus.rs2_data;
      end
      fin = wdone && (!rv || (got && bus.rd_rsp_ready));
      @(posedge clk); #1;
      if (wdone) bus.wb_valid = 1'b0;
      if (racc) bus.rd_req_valid = 1'b0;
    end
    if (!fin) chk("txn_timeout", 0, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, w0, n0, seen, i;
    logic [XLEN-1:0] d1, d2;
    bus.wb_valid = 1'b0; bus.wb_idx = '0; bus.wb_data = '0;
    bus.rd_req_valid = 1'b0; bus.rs1_idx = '0; bus.rs2_idx = '0;
    bus.rd_rsp_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", bus.wb_ready, 0);
    @(negedge clk);
    chk("ready_after_first_edge", bus.wb_ready, 1);
    chk("dbg_state_idle", dbg_state, IDLE);
    @(posedge clk); #1;

    // Write x5 = 0xDEADBEEF: one strobe, two write-enable cycles.
    w0 = wstrobe_cnt; n0 = wn_low_cnt;
    run_txn(1, 5, 32'hDEADBEEF, 0, 0, 0, lat, d1, d2);
    idle_cycles(4);
    chk("wr5_strobes", wstrobe_cnt - w0, 1);
    chk("wr5_write_n_cycles", wn_low_cnt - n0, 2);
    chk("wr5_file", file_mem[5], 32'hDEADBEEF);

    // Read x5, x0.
    run_txn(0, 0, 0, 1, 5, 0, lat, d1, d2);
    chk("rd5_latency", lat, SHORT_LAT);
    chk("rd5_rs1", d1, 32'hDEADBEEF);
    chk("rd5_rs2", d2, 32'h0);
    idle_cycles(2);

    // Simultaneous writeback x7 and read x7/x5: write first, response at cycle 6.
    run_txn(1, 7, 32'h1234, 1, 7, 5, lat, d1, d2);
    chk("sim_latency", lat, 6);
    chk("sim_rs1", d1, 32'h1234);
    chk("sim_rs2", d2, 32'hDEADBEEF);
    idle_cycles(2);

    // Write to x0 is swallowed; x0 reads back zero.
    w0 = wstrobe_cnt;
    run_txn(1, 0, 32'hFFFFFFFF, 0, 0, 0, lat, d1, d2);
    idle_cycles(3);
    chk("wr0_no_strobe", wstrobe_cnt - w0, 0);
    chk("wr0_file", file_mem[0], 0);
    run_txn(0, 0, 0, 1, 0, 0, lat, d1, d2);
    chk("rd0_latency", lat, SHORT_LAT);
    chk("rd0_data", {d1, d2}, 64'h0);
    idle_cycles(2);

    // A couple more registers.
    run_txn(1, 31, 32'hA5A55A5A, 0, 0, 0, lat, d1, d2);
    run_txn(1, 12, 32'h00000001, 0, 0, 0, lat, d1, d2);
    idle_cycles(4);
    run_txn(0, 0, 0, 1, 31, 12, lat, d1, d2);
    chk("rd31_12_latency", lat, 3);
    chk("rd31_12_data", {d1, d2}, {32'hA5A55A5A, 32'h00000001});
    idle_cycles(2);

    // Response backpressure for 10 cycles with a pending writeback held off.
    bus.rd_rsp_ready = 1'b0;
    bus.rd_req_valid = 1'b1; bus.rs1_idx = 12; bus.rs2_idx = 31;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rd_req_ready) break;
    end
    if (i == 20) chk("bp_accept_timeout", 0, 1);
    @(posedge clk); #1 bus.rd_req_valid = 1'b0;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rd_rsp_valid) break;
    end
    if (i == 20) chk("bp_rsp_timeout", 0, 1);
    @(posedge clk); #1;
    bus.wb_valid = 1'b1; bus.wb_idx = 9; bus.wb_data = 32'h99;
    repeat (10) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rd_rsp_valid, 1);
      chk("bp_rsp_data", {bus.rs1_data, bus.rs2_data}, {32'h00000001, 32'hA5A55A5A});
      chk("bp_wb_ready", bus.wb_ready, 0);
      chk("bp_rd_ready", bus.rd_req_ready, 0);
    end
    @(posedge clk); #1;
    bus.wb_valid = 1'b0;
    bus.rd_rsp_ready = 1'b1;
    idle_cycles(3);
    chk("bp_wb_not_taken", file_mem[9], 0);

    // Reset asserted while the read strobe is high.
    bus.rd_req_valid = 1'b1; bus.rs1_idx = 5; bus.rs2_idx = 7;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rd_req_ready) break;
    end
    if (i == 20) chk("rst_rd_accept_timeout", 0, 1);
    @(posedge clk); #1 bus.rd_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("strobe_before_reset", bus.rf_req_r, 1);
    rst_n = 1'b0;
    #1;
    chk("strobe_async_drop", bus.rf_req_r, 0);
    chk("read_n_async_release", bus.rf_rs_read_n, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);
    chk("ready_after_reset", bus.wb_ready, 1);
    @(posedge clk); #1;

    // File contents survive the controller reset.
    run_txn(0, 0, 0, 1, 7, 31, lat, d1, d2);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_data", {d1, d2}, {32'h00001234, 32'hA5A55A5A});
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
